// File: rtl/rf_wport_arbiter.sv
// Register-file write-port owner: muxes the WB-stage result against a long-latency
// unit result, giving WB priority but forcing a starved LL result through after MAX_WAIT.
module rf_wport_arbiter #(
  parameter int D_WIDTH  = 32,
  parameter int RF_SIZE  = 5,
  parameter int MAX_WAIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wb_we,
  input  logic [RF_SIZE-1:0] wb_rd,
  input  logic [D_WIDTH-1:0] wb_alu_out,
  input  logic [D_WIDTH-1:0] wb_mem_data,
  input  logic               wb_mem_to_reg,
  input  logic               ll_valid,
  input  logic [RF_SIZE-1:0] ll_rd,
  input  logic [D_WIDTH-1:0] ll_data,
  output logic               ll_ready,
  output logic               wb_stall,
  output logic               rf_we,
  output logic [RF_SIZE-1:0] rf_waddr,
  output logic [D_WIDTH-1:0] rf_wdata
);

  localparam int            CW      = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_FORCE = 2'd2
  } state_t;

  state_t             r_state;
  logic [CW-1:0]      r_cnt;

  logic               w_wb_req;
  logic               w_ll_grant;
  logic               w_denied;
  logic [CW-1:0]      w_cnt_inc;
  logic [D_WIDTH-1:0] w_wb_data;

  assign w_wb_req   = wb_we & (wb_rd != '0);
  assign w_ll_grant = ll_valid & ll_ready;
  assign w_denied   = ll_valid & ~ll_ready;
  assign w_cnt_inc  = r_cnt + 1'b1;
  assign w_wb_data  = wb_mem_to_reg ? wb_mem_data : wb_alu_out;

  // In FORCE the LL result wins unconditionally and WB is frozen if it wanted the port.
  always_comb begin
    ll_ready = 1'b0;
    wb_stall = 1'b0;
    if (!rst) begin
      if (r_state == S_FORCE) begin
        ll_ready = 1'b1;
        wb_stall = w_wb_req;
      end else begin
        ll_ready = ll_valid & ~w_wb_req;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      if (w_ll_grant) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
      end else if (w_denied) begin
        r_cnt   <= w_cnt_inc;
        r_state <= (w_cnt_inc == MAX_CNT) ? S_FORCE : S_WAIT;
      end else begin
        // No LL request (or it was withdrawn mid-wait): start over.
        r_state <= S_IDLE;
        r_cnt   <= '0;
      end

      if (w_ll_grant) begin
        rf_we    <= (ll_rd != '0);
        rf_waddr <= ll_rd;
        rf_wdata <= ll_data;
      end else if (w_wb_req && !wb_stall) begin
        rf_we    <= 1'b1;
        rf_waddr <= wb_rd;
        rf_wdata <= w_wb_data;
      end else begin
        rf_we    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Scenario bench for rf_wport_arbiter: combinational grant/stall checked inline,
// register-file writes checked through a queue of expected writes.
module tb_rf_wport_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk;
  logic          rst;
  logic          wb_we;
  logic [AW-1:0] wb_rd;
  logic [DW-1:0] wb_alu_out;
  logic [DW-1:0] wb_mem_data;
  logic          wb_mem_to_reg;
  logic          ll_valid;
  logic [AW-1:0] ll_rd;
  logic [DW-1:0] ll_data;
  logic          ll_ready;
  logic          wb_stall;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t sb_q[$];
  int  passed = 0;
  int  total  = 0;

  rf_wport_arbiter #(.D_WIDTH(DW), .RF_SIZE(AW), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_alu_out(wb_alu_out),
    .wb_mem_data(wb_mem_data), .wb_mem_to_reg(wb_mem_to_reg),
    .ll_valid(ll_valid), .ll_rd(ll_rd), .ll_data(ll_data),
    .ll_ready(ll_ready), .wb_stall(wb_stall),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: run did not finish (passed %0d of %0d)", passed, total);
    $fatal(1);
  end

  // Each entry describes the write expected one edge after its stimulus cycle.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      wr_t e;
      e = sb_q.pop_front();
      total++;
      if (rf_we !== e.we || (e.we && (rf_waddr !== e.addr || rf_wdata !== e.data)))
        $display("FAIL rf_write: got we=%b addr=%0d data=%h, expected we=%b addr=%0d data=%h",
                 rf_we, rf_waddr, rf_wdata, e.we, e.addr, e.data);
      else
        passed++;
    end
  end

  task automatic drive_wb(input logic we, input logic [AW-1:0] rd, input logic [DW-1:0] alu,
                          input logic [DW-1:0] mem, input logic m2r);
    wb_we = we; wb_rd = rd; wb_alu_out = alu; wb_mem_data = mem; wb_mem_to_reg = m2r;
  endtask

  task automatic drive_ll(input logic v, input logic [AW-1:0] rd, input logic [DW-1:0] d);
    ll_valid = v; ll_rd = rd; ll_data = d;
  endtask

  task automatic push(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    wr_t e;
    e.we = we; e.addr = addr; e.data = data;
    sb_q.push_back(e);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_wb(1'b1, 5'd5, 32'h11, 32'h22, 1'b1);
    drive_ll(1'b1, 5'd7, 32'hDEAD);
    repeat (2) @(posedge clk);
    #1;
    total++; if (ll_ready !== 1'b0) $display("FAIL reset_ll_ready: got %b want 0", ll_ready); else passed++;
    total++; if (wb_stall !== 1'b0) $display("FAIL reset_wb_stall: got %b want 0", wb_stall); else passed++;
    total++; if (rf_we !== 1'b0) $display("FAIL reset_rf_we: got %b want 0", rf_we); else passed++;
    total++; if (rf_waddr !== '0 || rf_wdata !== '0)
      $display("FAIL reset_addr_data: got %0d/%h want 0/0", rf_waddr, rf_wdata); else passed++;
    @(negedge clk);
    rst = 1'b0;
    drive_wb(1'b0, '0, '0, '0, 1'b0);
    drive_ll(1'b0, '0, '0);
  endtask

  task automatic test_wb_only();
    logic [DW-1:0] alu_v [3] = '{32'h11, 32'h11, 32'h11};
    logic          m2r_v [3] = '{1'b1, 1'b0, 1'b0};
    logic [AW-1:0] rd_v  [3] = '{5'd5, 5'd5, 5'd0};
    logic [DW-1:0] exp_d [3] = '{32'h22, 32'h11, 32'h0};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive_wb(1'b1, rd_v[i], alu_v[i], 32'h22, m2r_v[i]);
      drive_ll(1'b0, '0, '0);
      #1;
      total++; if (ll_ready !== 1'b0 || wb_stall !== 1'b0)
        $display("FAIL wb_only_ctrl[%0d]: got rdy=%b stall=%b want 0/0", i, ll_ready, wb_stall); else passed++;
      push(rd_v[i] != 0, rd_v[i], exp_d[i]);
    end
    @(negedge clk);
    drive_wb(1'b0, '0, '0, '0, 1'b0);
  endtask

  task automatic test_ll_only();
    @(negedge clk);
    drive_wb(1'b0, 5'd3, 32'h1, 32'h2, 1'b0);
    drive_ll(1'b1, 5'd7, 32'hDEAD);
    #1;
    total++; if (ll_ready !== 1'b1 || wb_stall !== 1'b0)
      $display("FAIL ll_only_ctrl: got rdy=%b stall=%b want 1/0", ll_ready, wb_stall); else passed++;
    push(1'b1, 5'd7, 32'hDEAD);
    @(negedge clk);
    drive_ll(1'b0, '0, '0);
    #1;
    push(1'b0, '0, '0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive_wb(1'b0, '0, '0, '0, 1'b0);
      drive_ll(1'b1, AW'(i + 1), 32'hA000 + DW'(i));
      #1;
      total++; if (ll_ready !== 1'b1)
        $display("FAIL b2b_ready[%0d]: got %b want 1", i, ll_ready); else passed++;
      push(1'b1, AW'(i + 1), 32'hA000 + DW'(i));
    end
    @(negedge clk);
    drive_ll(1'b0, '0, '0);
  endtask

  // Holds an LL request against continuous WB traffic: 4 denials then FORCE.
  task automatic starve(input string tag, input logic [AW-1:0] lrd, input logic [DW-1:0] ldat,
                        input logic [AW-1:0] wb_base);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive_wb(1'b1, wb_base + AW'(i), 32'h100 + DW'(i), 32'h0, 1'b0);
      drive_ll(1'b1, lrd, ldat);
      #1;
      total++; if (ll_ready !== 1'b0 || wb_stall !== 1'b0)
        $display("FAIL %s_deny[%0d]: got rdy=%b stall=%b want 0/0", tag, i, ll_ready, wb_stall); else passed++;
      push(1'b1, wb_base + AW'(i), 32'h100 + DW'(i));
    end
    @(negedge clk);
    drive_wb(1'b1, 5'd20, 32'h200, 32'h0, 1'b0);
    #1;
    total++; if (ll_ready !== 1'b1 || wb_stall !== 1'b1)
      $display("FAIL %s_force: got rdy=%b stall=%b want 1/1", tag, ll_ready, wb_stall); else passed++;
    push(lrd != 0, lrd, ldat);
    @(negedge clk);
    drive_ll(1'b0, '0, '0);
    #1;
    total++; if (ll_ready !== 1'b0 || wb_stall !== 1'b0)
      $display("FAIL %s_after: got rdy=%b stall=%b want 0/0", tag, ll_ready, wb_stall); else passed++;
    push(1'b1, 5'd20, 32'h200);
    @(negedge clk);
    drive_wb(1'b0, '0, '0, '0, 1'b0);
  endtask

  task automatic test_starvation();
    starve("starve", 5'd9, 32'hBEEF, 5'd10);
  endtask

  task automatic test_collision_rd0();
    starve("rd0", 5'd0, 32'h55, 5'd12);
    starve("rd0_again", 5'd3, 32'h77, 5'd14);
  endtask

  task automatic test_abort();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive_wb(1'b1, 5'd16, 32'h300, 32'h0, 1'b0);
      drive_ll(1'b1, 5'd4, 32'h44);
      #1;
      total++; if (ll_ready !== 1'b0)
        $display("FAIL abort_deny[%0d]: got rdy=%b want 0", i, ll_ready); else passed++;
      push(1'b1, 5'd16, 32'h300);
    end
    @(negedge clk);
    drive_ll(1'b0, '0, '0);
    #1;
    total++; if (ll_ready !== 1'b0 || wb_stall !== 1'b0)
      $display("FAIL abort_drop: got rdy=%b stall=%b want 0/0", ll_ready, wb_stall); else passed++;
    push(1'b1, 5'd16, 32'h300);
    starve("abort_new", 5'd6, 32'h66, 5'd24);
  endtask

  initial begin
    rst = 1'b1;
    drive_wb(1'b0, '0, '0, '0, 1'b0);
    drive_ll(1'b0, '0, '0);
    test_reset();
    test_wb_only();
    test_ll_only();
    test_back_to_back();
    test_starvation();
    test_collision_rd0();
    test_abort();
    repeat (3) @(negedge clk);
    #2;
    total++; if (sb_q.size() != 0)
      $display("FAIL sb_drain: %0d expected writes never observed, want 0", sb_q.size()); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
